ifetch_prefetch_buf: RTL and testbench

Parametrised instruction-fetch front end between the PC stage and instruction memory.
- Keeps up to MAX_OUTSTANDING granted requests in flight.
- Tags each in-order response with its PC and buffers {pc, instr} pairs in an output FIFO toward decode.
- Flushes on branch/jump and silently discards responses that were in flight at the flush.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_sync_fifo.sv | 60 ++++++
 rtl/ifetch_prefetch_buf.sv | 158 +++++++++++++++
 tb/tb_ifetch_prefetch_buf.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch prefetch buffer.
// The optional zero-latency response path is enabled with IFETCH_BYPASS_EN.
package ifetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACTIVE = 2'b01,
      S_DRAIN  = 2'b10
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

endpackage

// File: rtl/ifetch_sync_fifo.sv
// Synchronous FIFO with flush, async active-low reset and occupancy count.
// Pop is ignored when empty; push while full is accepted only alongside a pop.
module ifetch_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Instruction-fetch front end: credit-limited request issue, PC tagging of in-order
// responses, output queue toward decode, and flush with discard of in-flight data.
// Optional IFETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
//
// state    | meaning
// S_IDLE   | nothing outstanding, output queue empty
// S_ACTIVE | fetches in flight or buffered, no pending discards
// S_DRAIN  | responses from before a flush still being discarded
module ifetch_prefetch_buf
   import ifetch_pkg::*;
#(
   parameter int               XLEN            = 32,
   parameter int               MAX_OUTSTANDING = 2,
   parameter int               FIFO_DEPTH      = 4,
   parameter logic [XLEN-1:0]  NOP_INSTR       = XLEN'(ifetch_pkg::NOP_INSTR)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [XLEN-1:0] pc_i,
   input  logic            pc_i_valid,
   output logic            pc_ready_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            instr_valid_o,
   input  logic            instr_ready_i,
   input  logic            flush_i,
   output logic            idle_o,
   output logic            err_o,
   output logic            data_clk,
   output logic            data_req_o,
   output logic [XLEN-1:0] data_addr_o,
   output logic            data_we_o,
   output logic [3:0]      data_be_o,
   output logic [XLEN-1:0] data_wdata_o,
   input  logic [XLEN-1:0] data_rdata_i,
   input  logic            data_rvalid_i,
   input  logic            data_gnt_i
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = OW + FW + 1;

   state_t            r_state;
   logic [OW-1:0]     r_discard;
   logic              r_err;

   logic [OW-1:0]     w_outstanding;
   logic              w_tfifo_full;
   logic              w_tfifo_empty;
   logic [XLEN-1:0]   w_tag;
   logic [FW-1:0]     w_ofifo_count;
   logic              w_ofifo_full;
   logic              w_ofifo_empty;
   logic [2*XLEN-1:0] w_head;
   logic [SW-1:0]     w_credits_used;
   logic [OW-1:0]     w_left_after_flush;
   logic              w_can_issue;
   logic              w_req;
   logic              w_grant;
   logic              w_rv;
   logic              w_keep;
   logic              w_bypass;
   logic              w_ofifo_push;
   logic              w_ofifo_pop;

   // The tag FIFO occupancy is the outstanding-request count.
   ifetch_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_push  (w_grant),
      .i_wdata (pc_i),
      .i_pop   (w_rv),
      .i_flush (1'b0),
      .o_rdata (w_tag),
      .o_full  (w_tfifo_full),
      .o_empty (w_tfifo_empty),
      .o_count (w_outstanding)
   );

   ifetch_sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_push  (w_ofifo_push),
      .i_wdata ({w_tag, data_rdata_i}),
      .i_pop   (w_ofifo_pop),
      .i_flush (flush_i),
      .o_rdata (w_head),
      .o_full  (w_ofifo_full),
      .o_empty (w_ofifo_empty),
      .o_count (w_ofifo_count)
   );

   // Responses still owed to decode plus queued entries must fit in the output queue.
   assign w_credits_used     = SW'(w_outstanding) - SW'(r_discard) + SW'(w_ofifo_count);
   assign w_can_issue        = (w_credits_used < SW'(FIFO_DEPTH)) && !w_tfifo_full && !w_ofifo_full;
   assign w_req              = pc_i_valid && w_can_issue && !flush_i;
   assign w_grant            = w_req && data_gnt_i;
   assign w_rv               = data_rvalid_i && !w_tfifo_empty;
   assign w_keep             = w_rv && !flush_i && (r_discard == '0);
   assign w_left_after_flush = w_outstanding - OW'(w_rv);

`ifdef IFETCH_BYPASS_EN
   assign w_bypass = w_keep && w_ofifo_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_ofifo_pop  = !w_ofifo_empty && instr_ready_i;
   assign w_ofifo_push = w_keep && !(w_bypass && instr_ready_i);

   assign instr_valid_o = !w_ofifo_empty || w_bypass;
   assign instr_o       = w_bypass ? data_rdata_i :
                          (!w_ofifo_empty ? w_head[XLEN-1:0] : NOP_INSTR);
   assign instr_pc_o    = w_bypass ? w_tag :
                          (!w_ofifo_empty ? w_head[2*XLEN-1:XLEN] : '0);

   assign pc_ready_o   = w_grant;
   assign data_req_o   = w_req;
   assign data_addr_o  = w_req ? pc_i : '0;
   assign data_clk     = clk;
   assign data_we_o    = 1'b0;
   assign data_be_o    = 4'b1111;
   assign data_wdata_o = '0;
   assign err_o        = r_err;
   assign idle_o       = (r_state == S_IDLE) && !pc_i_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_discard <= '0;
         r_err     <= 1'b0;
      end else begin
         if (data_rvalid_i && w_tfifo_empty) r_err <= 1'b1;

         if (flush_i)                         r_discard <= w_left_after_flush;
         else if (w_rv && r_discard != '0)    r_discard <= r_discard - 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_grant) r_state <= S_ACTIVE;
            end
            S_ACTIVE: begin
               if (flush_i && w_left_after_flush != '0)
                  r_state <= S_DRAIN;
               else if (w_tfifo_empty && w_ofifo_empty && !w_grant)
                  r_state <= S_IDLE;
            end
            S_DRAIN: begin
               if (!flush_i && r_discard == '0)
                  r_state <= (!w_tfifo_empty || !w_ofifo_empty || w_grant) ? S_ACTIVE : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Bench for ifetch_prefetch_buf: directed steps plus random traffic against a
// queue-based model of in-flight fetches and the decode-side queue.
module tb_ifetch_prefetch_buf;
   import ifetch_pkg::*;

   localparam int MAXO  = 2;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] pc_i = '0;
   logic        pc_i_valid = 1'b0;
   logic        pc_ready_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        idle_o;
   logic        err_o;
   logic        data_clk;
   logic        data_req_o;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic [31:0] data_rdata_i = '0;
   logic        data_rvalid_i = 1'b0;
   logic        data_gnt_i = 1'b0;

   ifetch_prefetch_buf dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_i          (pc_i),
      .pc_i_valid    (pc_i_valid),
      .pc_ready_o    (pc_ready_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .flush_i       (flush_i),
      .idle_o        (idle_o),
      .err_o         (err_o),
      .data_clk      (data_clk),
      .data_req_o    (data_req_o),
      .data_addr_o   (data_addr_o),
      .data_we_o     (data_we_o),
      .data_be_o     (data_be_o),
      .data_wdata_o  (data_wdata_o),
      .data_rdata_i  (data_rdata_i),
      .data_rvalid_i (data_rvalid_i),
      .data_gnt_i    (data_gnt_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      bit          drop;
   } flight_t;

   flight_t     flight_q[$];
   entry_t      out_q[$];
   logic [31:0] mem_q[$];
   bit          exp_err;
   bit          last_grant;
   logic        obs_valid;
   logic [31:0] obs_pc;
   int          n_gnt_obs;
   int          n_tests = 0;
   int          n_fail = 0;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'hc3c3};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs at negedge, check outputs, then advance the model.
   task automatic cycle(input bit v, input logic [31:0] pc, input bit g, input bit rv,
                        input bit rdy, input bit fl);
      int      ndrop;
      bit      exp_req, exp_grant, kept, byp, exp_valid;
      entry_t  head;
      flight_t f;
      @(negedge clk);
      pc_i_valid    = v;
      pc_i          = pc;
      data_gnt_i    = g;
      data_rvalid_i = rv;
      instr_ready_i = rdy;
      flush_i       = fl;
      data_rdata_i  = (mem_q.size() > 0) ? mem_data(mem_q[0]) : 32'hdead_beef;

      ndrop = 0;
      foreach (flight_q[i]) if (flight_q[i].drop) ndrop++;
      exp_req   = v && !fl && (flight_q.size() < MAXO) &&
                  (flight_q.size() - ndrop + out_q.size() < DEPTH);
      exp_grant = exp_req && g;
      kept = 1'b0;
      if (rv && flight_q.size() > 0) kept = !fl && !flight_q[0].drop;
      byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
      byp = kept && (out_q.size() == 0);
`endif
      exp_valid = (out_q.size() > 0) || byp;
      if (out_q.size() > 0) head = out_q[0];
      else if (byp)         head = '{pc: flight_q[0].pc, instr: data_rdata_i};
      else                  head = '{pc: 32'h0, instr: NOP_INSTR};

      #1;
      chk("data_req", data_req_o, exp_req);
      chk("data_addr", data_addr_o, exp_req ? pc : 32'h0);
      chk("pc_ready", pc_ready_o, exp_grant);
      chk("instr_valid", instr_valid_o, exp_valid);
      chk("instr", instr_o, head.instr);
      chk("instr_pc", instr_pc_o, head.pc);
      chk("err", err_o, exp_err);
      obs_valid  = instr_valid_o;
      obs_pc     = instr_pc_o;
      n_gnt_obs += int'(pc_ready_o);
      last_grant = exp_grant;

      if (exp_valid && rdy && !byp) void'(out_q.pop_front());
      if (rv) begin
         if (flight_q.size() == 0) exp_err = 1'b1;
         else begin
            f = flight_q.pop_front();
            void'(mem_q.pop_front());
            if (kept && !(byp && rdy)) out_q.push_back('{pc: f.pc, instr: data_rdata_i});
         end
      end
      if (fl) begin
         out_q.delete();
         foreach (flight_q[i]) flight_q[i].drop = 1'b1;
      end
      if (exp_grant) begin
         flight_q.push_back('{pc: pc, drop: 1'b0});
         mem_q.push_back(pc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      pc_i_valid    = 1'b0;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      flush_i       = 1'b0;
      reset_n       = 1'b0;
      #1;
      chk("rst_instr_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, NOP_INSTR);
      chk("rst_instr_pc", instr_pc_o, 0);
      chk("rst_data_req", data_req_o, 0);
      chk("rst_pc_ready", pc_ready_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_idle", idle_o, 1);
      chk("data_we", data_we_o, 0);
      chk("data_be", data_be_o, 4'b1111);
      chk("data_wdata", data_wdata_o, 0);
      flight_q.delete();
      out_q.delete();
      mem_q.delete();
      exp_err = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 40 && (mem_q.size() > 0 || out_q.size() > 0); k++)
         cycle(0, 32'h0, 0, mem_q.size() > 0, 1, 0);
      chk(tag, mem_q.size() + out_q.size(), 0);
   endtask

   task automatic settle_idle(input string tag);
      repeat (3) cycle(0, 32'h0, 0, 0, 1, 0);
      chk(tag, idle_o, 1);
   endtask

   initial begin
      logic [31:0] pc_cur;
      do_reset();

      // Back-to-back fetch with one-cycle responses.
      cycle(1, 32'h0, 1, 0, 1, 0);
      cycle(1, 32'h4, 1, 1, 1, 0);
      cycle(1, 32'h8, 1, 1, 1, 0);
      cycle(0, 32'h0, 0, 1, 1, 0);
      cycle(0, 32'h0, 0, 0, 1, 0);
      settle_idle("idle_after_stream");

      // Request held while memory withholds grant.
      repeat (3) cycle(1, 32'h40, 0, 0, 1, 0);
      cycle(1, 32'h40, 1, 0, 1, 0);
      cycle(0, 32'h0, 0, 1, 1, 0);
      drain("drain_hold");
      settle_idle("idle_after_hold");

      // Decode stalled: credits stop issue at the output queue depth.
      pc_cur    = 32'h1000;
      n_gnt_obs = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(1, pc_cur, 1, mem_q.size() > 0, 0, 0);
         if (last_grant) pc_cur += 32'h4;
      end
      chk("stall_grants", n_gnt_obs, 4);
      chk("stall_req_low", data_req_o, 0);
      for (int k = 0; k < 6; k++) begin
         cycle(1, pc_cur, 1, mem_q.size() > 0, 1, 0);
         if (last_grant) pc_cur += 32'h4;
      end
      drain("drain_stall");
      settle_idle("idle_after_stall");

      // Flush with two in flight, then branch target.
      cycle(1, 32'h10, 1, 0, 1, 0);
      cycle(1, 32'h14, 1, 0, 1, 0);
      cycle(1, 32'h100, 0, 0, 1, 1);
      cycle(1, 32'h100, 1, 1, 1, 0);
      cycle(1, 32'h100, 1, 1, 1, 0);
      cycle(0, 32'h0, 0, 1, 1, 0);
      cycle(0, 32'h0, 0, 0, 1, 0);
      chk("flush_first_valid", obs_valid, 1);
      chk("flush_first_pc", obs_pc, 32'h100);
      settle_idle("idle_after_flush");

      // Flush coinciding with the only response.
      cycle(1, 32'h20, 1, 0, 1, 0);
      cycle(0, 32'h0, 0, 1, 1, 1);
      settle_idle("idle_after_flush_rv");
      chk("flush_rv_no_instr", instr_valid_o, 0);

      // Spurious response sets a sticky error.
      cycle(0, 32'h0, 0, 1, 1, 0);
      repeat (3) cycle(0, 32'h0, 0, 0, 1, 0);
      chk("err_sticky", err_o, 1);

      // Reset in the middle of a burst.
      cycle(1, 32'h200, 1, 0, 1, 0);
      cycle(1, 32'h204, 1, 1, 0, 0);
      do_reset();

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom % 4) != 0, $urandom & 32'h0000_fffc, ($urandom % 3) != 0,
               (($urandom % 2) == 1) && (mem_q.size() > 0), ($urandom % 4) != 0,
               ($urandom % 20) == 0);
      end
      drain("drain_random");
      settle_idle("idle_after_random");

      @(negedge clk);
      pc_i_valid = 1'b1;
      data_gnt_i = 1'b0;
      #1;
      chk("idle_busy", idle_o, 0);
      pc_i_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
